// File: rtl/tcdm_bank_responder.sv
// TCDM responder: loads, stores and atomics against one 1-cycle-latency SRAM bank,
// answering in acceptance order through a credit-guarded fall-through response FIFO.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | accepting requests while credits remain
// ST_AMO_WB | atomic read data present; write back new value, respond
module tcdm_bank_responder #(
   parameter int NumWords  = 1024,
   parameter int IdWidth   = 5,
   parameter int RespDepth = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [31:0]                 req_addr_i,
   input  logic                        req_write_i,
   input  logic [3:0]                  req_amo_i,
   input  logic [31:0]                 req_data_i,
   input  logic [3:0]                  req_strb_i,
   input  logic [IdWidth-1:0]          req_id_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   output logic [31:0]                 resp_data_o,
   output logic                        resp_error_o,
   output logic [IdWidth-1:0]          resp_id_o,
   output logic                        resp_valid_o,
   input  logic                        resp_ready_i,
   output logic                        sram_req_o,
   output logic                        sram_we_o,
   output logic [$clog2(NumWords)-1:0] sram_addr_o,
   output logic [31:0]                 sram_wdata_o,
   output logic [3:0]                  sram_be_o,
   input  logic [31:0]                 sram_rdata_i
);
   localparam int AW = $clog2(NumWords);
   localparam int CW = $clog2(RespDepth) + 1;
   localparam int PW = $clog2(RespDepth);
   localparam int NW = $clog2(RespDepth + 1);
   localparam int EW = 33 + IdWidth;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_AMO_WB = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [CW-1:0]      cred_q, cred_d;
   logic               store_ret_q, store_ret_d;
   logic               pend_q, pend_d;
   logic               err_q, err_d;
   logic [IdWidth-1:0] id_q, id_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [31:0]        opnd_q, opnd_d;
   logic [3:0]         amo_q, amo_d;
   logic [EW-1:0]      fifo_q [RespDepth];
   logic [EW-1:0]      fifo_d [RespDepth];
   logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
   logic [NW-1:0]      cnt_q, cnt_d;

   logic          accept, amo_ok, amo_bad, is_store;
   logic          push, pop, empty;
   logic [AW-1:0] word_idx;
   logic [31:0]   amo_new;
   logic [EW-1:0] push_entry, head;
   logic          unused_addr;

   assign word_idx    = req_addr_i[2 +: AW];
   assign unused_addr = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};

   assign amo_ok      = (req_amo_i != 4'd0) && (req_amo_i <= 4'd9);
   assign amo_bad     = (req_amo_i >= 4'd10);
   assign is_store    = (req_amo_i == 4'd0) && req_write_i;
   assign req_ready_o = (state_q == ST_IDLE) && (cred_q != '0);
   assign accept      = req_valid_i && req_ready_o;

   // Ties keep the old value, so only a strict win replaces it.
   always_comb begin
      amo_new = sram_rdata_i;
      case (amo_q)
         4'd1: amo_new = opnd_q;
         4'd2: amo_new = sram_rdata_i + opnd_q;
         4'd3: amo_new = sram_rdata_i & opnd_q;
         4'd4: amo_new = sram_rdata_i | opnd_q;
         4'd5: amo_new = sram_rdata_i ^ opnd_q;
         4'd6: if ($signed(opnd_q) > $signed(sram_rdata_i)) amo_new = opnd_q;
         4'd7: if (opnd_q > sram_rdata_i) amo_new = opnd_q;
         4'd8: if ($signed(opnd_q) < $signed(sram_rdata_i)) amo_new = opnd_q;
         4'd9: if (opnd_q < sram_rdata_i) amo_new = opnd_q;
         default: amo_new = sram_rdata_i;
      endcase
   end

   always_comb begin
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      if (state_q == ST_AMO_WB) begin
         sram_req_o   = 1'b1;
         sram_we_o    = 1'b1;
         sram_addr_o  = addr_q;
         sram_wdata_o = amo_new;
         sram_be_o    = 4'hF;
      end else if (accept && !amo_bad) begin
         sram_req_o   = 1'b1;
         sram_we_o    = is_store;
         sram_addr_o  = word_idx;
         sram_wdata_o = is_store ? req_data_i : '0;
         sram_be_o    = is_store ? req_strb_i : 4'hF;
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      if ((state_q == ST_IDLE) && accept && amo_ok) state_d = ST_AMO_WB;
      store_ret_d = accept && is_store;
      pend_d      = accept && !is_store;
      err_d       = err_q;
      id_d        = id_q;
      addr_d      = addr_q;
      opnd_d      = opnd_q;
      amo_d       = amo_q;
      if (accept) begin
         err_d  = amo_bad;
         id_d   = req_id_i;
         addr_d = word_idx;
         opnd_d = req_data_i;
         amo_d  = req_amo_i;
      end
      // A store's credit comes back one cycle after it was taken.
      cred_d = cred_q - CW'(accept) + CW'(pop) + CW'(store_ret_q);
   end

   assign push         = pend_q;
   assign push_entry   = {err_q, (err_q ? 32'd0 : sram_rdata_i), id_q};
   assign empty        = (cnt_q == '0);
   assign head         = empty ? push_entry : fifo_q[rd_q];
   assign resp_valid_o = !empty || push;
   assign pop          = resp_valid_o && resp_ready_i;
   assign {resp_error_o, resp_data_o, resp_id_o} = resp_valid_o ? head : '0;

   always_comb begin
      fifo_d = fifo_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      if (push) begin
         fifo_d[wr_q] = push_entry;
         wr_d = (wr_q == PW'(RespDepth - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop) rd_d = (rd_q == PW'(RespDepth - 1)) ? '0 : rd_q + 1'b1;
      cnt_d = cnt_q + NW'(push) - NW'(pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cred_q      <= CW'(RespDepth);
         store_ret_q <= 1'b0;
         pend_q      <= 1'b0;
         err_q       <= 1'b0;
         id_q        <= '0;
         addr_q      <= '0;
         opnd_q      <= '0;
         amo_q       <= '0;
         rd_q        <= '0;
         wr_q        <= '0;
         cnt_q       <= '0;
         for (int i = 0; i < RespDepth; i++) fifo_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cred_q      <= cred_d;
         store_ret_q <= store_ret_d;
         pend_q      <= pend_d;
         err_q       <= err_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         opnd_q      <= opnd_d;
         amo_q       <= amo_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         fifo_q      <= fifo_d;
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && !pop && (cnt_q == NW'(RespDepth))));

endmodule
